// File: rtl/mob_table_loader.sv
// -----------------------------------------------------------------------------
// mob_table_loader
//
// Once per frame, copies the 48-byte motion-object shadow table from work RAM
// into the motion-object MMIO write window, using the same addr/data/we_l
// strobe the CPU uses. The bus is borrowed from the 6502 arbiter via
// bus_req/bus_gnt. Losing the grant mid-copy parks the loader in REQ, and the
// byte that was in flight is re-read on re-grant.
//
// Parameters:
//   SRC_BASE   first shadow-table byte in work RAM
//   DST_BASE   first byte of the motion-object MMIO window
//   NUM_BYTES  bytes per transfer (3 tables x 16 objects)
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   vblank_start  one-cycle pulse at the start of vertical blank
//   bus_gnt       arbiter grant; the bus is driven only while high
//   rd_data       RAM read data, valid the cycle after rd_en
//   bus_req       bus request to the arbiter
//   rd_en/rd_addr RAM read strobe and address
//   addr/data_out MMIO write address and data (data straight from rd_data)
//   we_l          active-low write strobe
//   busy          transfer in progress (REQ/FILL/XFER)
//   done          one-cycle pulse after the last byte is written
//   checksum      XOR of all bytes of the last completed transfer
//                 (present only with MOB_TABLE_LOADER_CHECKSUM_EN defined)
//
// Optional feature macro: MOB_TABLE_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module mob_table_loader #(
   parameter logic [15:0] SRC_BASE  = 16'h03C0,
   parameter logic [15:0] DST_BASE  = 16'h07C0,
   parameter int          NUM_BYTES = 48
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblank_start,
   input  logic        bus_gnt,
   input  logic [7:0]  rd_data,
`ifdef MOB_TABLE_LOADER_CHECKSUM_EN
   output logic [7:0]  checksum,
`endif
   output logic        bus_req,
   output logic        rd_en,
   output logic [15:0] rd_addr,
   output logic [15:0] addr,
   output logic [7:0]  data_out,
   output logic        we_l,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_FILL,
      S_XFER,
      S_DONE
   } state_t;

   localparam logic [15:0] LAST_K = 16'(NUM_BYTES - 1);

   state_t      state, state_nxt;
   logic [15:0] k, k_nxt;       // index of the byte currently being moved
   logic [15:0] addr_q;         // last written address, held outside XFER
   logic        wr;             // a write actually happens this cycle
   logic        start;

   assign start = (state == S_IDLE) && vblank_start;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create order-dependent
   // races between always_ff blocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         k      <= '0;
         addr_q <= '0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         if (wr) addr_q <= DST_BASE + k;
      end
   end

   // NOTE: every output and next-state signal gets a default before the case
   // statement, so no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      bus_req   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      rd_en     = 1'b0;
      rd_addr   = '0;
      we_l      = 1'b1;
      addr      = addr_q;
      data_out  = '0;
      wr        = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (vblank_start) begin
               state_nxt = S_REQ;
               k_nxt     = '0;
            end
         end

         S_REQ: begin
            bus_req = 1'b1;
            busy    = 1'b1;
            if (bus_gnt) state_nxt = S_FILL;
         end

         // Prime the read pipeline with byte k; rd_data is valid in XFER.
         S_FILL: begin
            bus_req   = 1'b1;
            busy      = 1'b1;
            rd_en     = 1'b1;
            rd_addr   = SRC_BASE + k;
            state_nxt = bus_gnt ? S_XFER : S_REQ;
         end

         // Write byte k and prefetch k+1 in the same cycle. A grant drop gates
         // the strobe and holds k, so FILL re-reads the same byte later.
         S_XFER: begin
            bus_req  = 1'b1;
            busy     = 1'b1;
            addr     = DST_BASE + k;
            data_out = rd_data;
            if (bus_gnt) begin
               wr    = 1'b1;
               we_l  = 1'b0;
               k_nxt = k + 16'd1;
               if (k == LAST_K) begin
                  state_nxt = S_DONE;
               end else begin
                  rd_en   = 1'b1;
                  rd_addr = SRC_BASE + k + 16'd1;
               end
            end else begin
               state_nxt = S_REQ;
            end
         end

         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end

         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef MOB_TABLE_LOADER_CHECKSUM_EN
   // Running XOR of the bytes written so far; published only when the
   // transfer completes, so a partial transfer never shows up on checksum.
   logic [7:0] csum_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_acc <= '0;
         checksum <= '0;
      end else begin
         if (start)   csum_acc <= '0;
         else if (wr) csum_acc <= csum_acc ^ rd_data;
         if (state == S_DONE) checksum <= csum_acc;
      end
   end
`else
   logic unused_start;
   assign unused_start = start;
`endif

endmodule

// File: tb/tb_mob_table_loader.sv
// -----------------------------------------------------------------------------
// tb_mob_table_loader
//
// Directed bench for mob_table_loader: a cycle-by-cycle vector table for the
// basic copy, then hand-written sequences for late grant, grant drop,
// retrigger while busy and reset mid-transfer. A small registered RAM model
// supplies rd_data one cycle after rd_en.
// -----------------------------------------------------------------------------
module tb_mob_table_loader;

   localparam logic [15:0] SRC = 16'h03C0;
   localparam logic [15:0] DST = 16'h07C0;
   localparam int          NB  = 48;

   logic        clk = 1'b0;
   logic        rst;
   logic        vblank_start;
   logic        bus_gnt;
   logic [7:0]  rd_data;
   logic        bus_req;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [15:0] addr;
   logic [7:0]  data_out;
   logic        we_l;
   logic        busy;
   logic        done;
`ifdef MOB_TABLE_LOADER_CHECKSUM_EN
   logic [7:0]  checksum;
`endif

   mob_table_loader dut (
      .clk          (clk),
      .rst          (rst),
      .vblank_start (vblank_start),
      .bus_gnt      (bus_gnt),
      .rd_data      (rd_data),
`ifdef MOB_TABLE_LOADER_CHECKSUM_EN
      .checksum     (checksum),
`endif
      .bus_req      (bus_req),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .addr         (addr),
      .data_out     (data_out),
      .we_l         (we_l),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Work RAM model: registered read port.
   logic [7:0] mem [0:65535];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int n_vec = 0;
   int n_err = 0;

   // Write scoreboard, filled by step().
   int         n_writes;
   int         n_done;
   int         wcount [0:NB-1];
   logic [7:0] wdata  [0:NB-1];
   int         bad_addr_writes;

   typedef struct {
      logic        vb;
      logic        gnt;
      logic        busy;
      logic        req;
      logic        we_l;
      logic        done;
      logic        rd_en;
      logic [15:0] rd_addr;
      logic [15:0] addr;
      logic [7:0]  data;
   } vec_t;

   vec_t tbl [0:52];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      n_writes = 0;
      n_done = 0;
      bad_addr_writes = 0;
      for (int i = 0; i < NB; i++) begin
         wcount[i] = 0;
         wdata[i] = 8'h00;
      end
   endtask

   // One clock cycle: drive inputs just after the rising edge, sample outputs
   // on the falling edge and log any write that happened in the cycle.
   task automatic step(input logic vb, input logic g);
      @(posedge clk);
      #1;
      vblank_start = vb;
      bus_gnt      = g;
      @(negedge clk);
      if (we_l == 1'b0) begin
         n_writes++;
         if (addr >= DST && addr < DST + 16'(NB)) begin
            wcount[addr - DST]++;
            wdata[addr - DST] = data_out;
         end else begin
            bad_addr_writes++;
         end
      end
      if (done) n_done++;
   endtask

   // Every address written exactly once with the RAM byte behind it.
   task automatic check_log(input string name);
      int ok;
      ok = 1;
      for (int i = 0; i < NB; i++)
         if (wcount[i] != 1 || wdata[i] !== mem[SRC + 16'(i)]) ok = 0;
      check({name, " writes"}, 64'(n_writes), 64'(NB));
      check({name, " each-once"}, 64'({ok, bad_addr_writes}), 64'({32'd1, 32'd0}));
   endtask

   task automatic check_reset_outputs(input string name);
      check(name,
            {bus_req, rd_en, rd_addr, addr, data_out, we_l, busy, done},
            {1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0});
   endtask

   initial begin
      vec_t v;
      int   steps, first_wr, ok;
      int   w_before;

      for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
      for (int i = 0; i < NB; i++) mem[SRC + 16'(i)] = 8'(i + 1);

      rst = 1'b1;
      vblank_start = 1'b0;
      bus_gnt = 1'b0;
      clear_log();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset state");
`ifdef MOB_TABLE_LOADER_CHECKSUM_EN
      check("reset checksum", 64'(checksum), 64'h0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;

      // ---- Basic copy: per-cycle expectations, vblank in cycle 0 ----
      for (int c = 0; c <= 52; c++) begin
         v = '{vb: (c == 0), gnt: 1'b1, busy: 1'b0, req: 1'b0, we_l: 1'b1,
               done: 1'b0, rd_en: 1'b0, rd_addr: 16'h0, addr: 16'h0, data: 8'h0};
         if (c >= 1 && c <= 50) begin v.busy = 1'b1; v.req = 1'b1; end
         if (c == 2) begin v.rd_en = 1'b1; v.rd_addr = 16'h03C0; end
         if (c >= 3 && c <= 50) begin
            v.we_l = 1'b0;
            v.addr = 16'h07C0 + 16'(c - 3);
            v.data = 8'(c - 2);
            if (c < 50) begin v.rd_en = 1'b1; v.rd_addr = 16'h03C0 + 16'(c - 2); end
         end
         if (c == 51) begin v.done = 1'b1; v.addr = 16'h07EF; end
         if (c == 52) v.addr = 16'h07EF;
         tbl[c] = v;
      end

      clear_log();
      for (int c = 0; c <= 52; c++) begin
         step(tbl[c].vb, tbl[c].gnt);
         check($sformatf("basic cycle %0d", c),
               {busy, bus_req, we_l, done, rd_en,
                (tbl[c].rd_en ? rd_addr : 16'h0), addr,
                (tbl[c].we_l ? 8'h0 : data_out)},
               {tbl[c].busy, tbl[c].req, tbl[c].we_l, tbl[c].done, tbl[c].rd_en,
                tbl[c].rd_addr, tbl[c].addr, tbl[c].data});
      end
      check_log("basic");
`ifdef MOB_TABLE_LOADER_CHECKSUM_EN
      check("checksum after done", 64'(checksum), 64'h30);
`endif

      // ---- Late grant: gnt low for 10 cycles after the request ----
      clear_log();
      step(1'b1, 1'b0);
      ok = 1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         if (!(bus_req && we_l)) ok = 0;
      end
      check("late grant wait req/we_l", 64'(ok), 64'h1);
      step(1'b0, 1'b1);                 // grant rises this cycle
      first_wr = -1;
      for (int i = 1; i <= 10 && first_wr < 0; i++) begin
         step(1'b0, 1'b1);
         if (!we_l) first_wr = i;
      end
      check("late grant first write delay", 64'(first_wr), 64'd2);
      steps = 0;
      while (!done && steps < 100) begin
         step(1'b0, 1'b1);
         steps++;
      end
      check("late grant done after first write", 64'(steps), 64'd48);
      check_log("late grant");

      // ---- Grant drop after the write to 0x07D4 ----
      clear_log();
      step(1'b1, 1'b1);
      steps = 0;
      while (!(we_l == 1'b0 && addr == 16'h07D4) && steps < 100) begin
         step(1'b0, 1'b1);
         steps++;
      end
      check("drop reached 07D4", 64'(addr), 64'h07D4);
      w_before = n_writes;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      check("drop no write in gap", 64'(n_writes), 64'(w_before));
      steps = 0;
      do begin
         step(1'b0, 1'b1);
         steps++;
      end while (we_l && steps < 20);
      check("drop resume addr/data", {addr, data_out}, {16'h07D5, 8'h16});
      steps = 0;
      while (!done && steps < 100) begin
         step(1'b0, 1'b1);
         steps++;
      end
      check_log("grant drop");

      // ---- Retrigger while busy ----
      clear_log();
      step(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);                 // ignored, transfer in progress
      for (int i = 0; i < 60; i++) step(1'b0, 1'b1);
      check("retrigger single done", 64'(n_done), 64'd1);
      check_log("retrigger");
      clear_log();
      step(1'b1, 1'b1);
      for (int i = 0; i < 55; i++) step(1'b0, 1'b1);
      check("retrigger after done", 64'({n_writes, n_done}), {32'd48, 32'd1});

      // ---- Reset mid-transfer after 20 writes ----
      clear_log();
      step(1'b1, 1'b1);
      steps = 0;
      while (n_writes < 20 && steps < 100) begin
         step(1'b0, 1'b1);
         steps++;
      end
      check("pre-reset writes", 64'(n_writes), 64'd20);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("async reset outputs");
`ifdef MOB_TABLE_LOADER_CHECKSUM_EN
      check("aborted checksum", 64'(checksum), 64'h0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      w_before = n_writes;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
      check("no writes after reset", 64'({n_writes, 31'(busy)}), 64'({w_before, 31'd0}));
      clear_log();
      step(1'b1, 1'b1);
      steps = 0;
      do begin
         step(1'b0, 1'b1);
         steps++;
      end while (we_l && steps < 20);
      check("restart first addr", 64'(addr), 64'h07C0);
      steps = 0;
      while (!done && steps < 100) begin
         step(1'b0, 1'b1);
         steps++;
      end
      check_log("restart");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
